control_sequencer: RTL and testbench

- Hardwired control unit that replaces the hand-stepped T0..T5 control stimulus used to bring up the datapath.
- Drives every datapath control strobe for instruction fetch and for register-register ALU instructions, including MUL/DIV with HI/LO writeback.
- Adds a memory-ready handshake, illegal-opcode trap, run/halt control and a retired-instruction counter.
- Sits between the IR output and the Datapath control inputs.

---
 rtl/control_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit: sequences fetch (T0..T2) and register-register
// ALU execution (T3..T6) strobes for the bus-based datapath.
module control_sequencer #(
   parameter int REG_SEL_W = 4,
   parameter int ALU_OP_W  = 4,
   parameter int OPC_W     = 5,
   parameter int CNT_W     = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 run,
   input  logic [31:0]          ir,
   input  logic                 mem_ready,
   output logic                 PCout,
   output logic                 Zlowout,
   output logic                 Zhighout,
   output logic                 MDRout,
   output logic                 Rout,
   output logic                 MARin,
   output logic                 Zin,
   output logic                 PCin,
   output logic                 MDRin,
   output logic                 IRin,
   output logic                 Yin,
   output logic                 Rin,
   output logic                 HIin,
   output logic                 LOin,
   output logic                 IncPC,
   output logic                 Read,
   output logic [REG_SEL_W-1:0] reg_select,
   output logic [ALU_OP_W-1:0]  ALU_operation,
   output logic                 instr_done,
   output logic                 illegal,
   output logic [CNT_W-1:0]     retired
);

   localparam logic [ALU_OP_W-1:0] ALU_NONE = ALU_OP_W'(13);
   localparam logic [OPC_W-1:0]    OPC_NEG  = OPC_W'(4);
   localparam logic [OPC_W-1:0]    OPC_NOT  = OPC_W'(5);
   localparam logic [OPC_W-1:0]    OPC_MUL  = OPC_W'(11);
   localparam logic [OPC_W-1:0]    OPC_DIV  = OPC_W'(12);
   localparam int                  RA_HI    = 31 - OPC_W;
   localparam int                  RB_HI    = RA_HI - REG_SEL_W;
   localparam int                  RC_HI    = RB_HI - REG_SEL_W;
   localparam int                  FREE_HI  = RC_HI - REG_SEL_W;

   // T1 is the first memory-read cycle; T1W holds the read while memory stalls.
   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     retired_q, retired_d;

   logic [OPC_W-1:0]     opc;
   logic [REG_SEL_W-1:0] ra, rb, rc;
   logic                 opc_legal, opc_unary, opc_muldiv;
   logic                 unused_ir_bits;

   assign opc            = ir[31 -: OPC_W];
   assign ra             = ir[RA_HI -: REG_SEL_W];
   assign rb             = ir[RB_HI -: REG_SEL_W];
   assign rc             = ir[RC_HI -: REG_SEL_W];
   assign unused_ir_bits = ^ir[FREE_HI:0];

   assign opc_legal  = (opc <= OPC_DIV);
   assign opc_unary  = (opc == OPC_NEG) || (opc == OPC_NOT);
   assign opc_muldiv = (opc == OPC_MUL) || (opc == OPC_DIV);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      retired_d = retired_q;
      if (instr_done) retired_d = retired_q + CNT_W'(1);
   end

   assign retired = retired_q;

   always_comb begin
      state_d       = state_q;
      PCout         = 1'b0;
      Zlowout       = 1'b0;
      Zhighout      = 1'b0;
      MDRout        = 1'b0;
      Rout          = 1'b0;
      MARin         = 1'b0;
      Zin           = 1'b0;
      PCin          = 1'b0;
      MDRin         = 1'b0;
      IRin          = 1'b0;
      Yin           = 1'b0;
      Rin           = 1'b0;
      HIin          = 1'b0;
      LOin          = 1'b0;
      IncPC         = 1'b0;
      Read          = 1'b0;
      reg_select    = '0;
      ALU_operation = ALU_NONE;
      instr_done    = 1'b0;
      illegal       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_T0;
         end
         S_T0: begin
            PCout   = 1'b1;
            MARin   = 1'b1;
            IncPC   = 1'b1;
            Zin     = 1'b1;
            state_d = S_T1;
         end
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
            state_d = mem_ready ? S_T2 : S_T1W;
         end
         S_T1W: begin
            Read  = 1'b1;
            MDRin = 1'b1;
            if (mem_ready) state_d = S_T2;
         end
         S_T2: begin
            MDRout  = 1'b1;
            IRin    = 1'b1;
            state_d = S_T3;
         end
         S_T3: begin
            if (!opc_legal) begin
               state_d = S_HALT;
            end else begin
               reg_select = rb;
               Rout       = 1'b1;
               Yin        = 1'b1;
               state_d    = S_T4;
            end
         end
         S_T4: begin
            // Unary ops still present rc but keep it off the bus; the ALU reads Y only.
            reg_select    = rc;
            Rout          = !opc_unary;
            ALU_operation = opc[ALU_OP_W-1:0];
            Zin           = 1'b1;
            state_d       = S_T5;
         end
         S_T5: begin
            Zlowout = 1'b1;
            if (opc_muldiv) begin
               LOin    = 1'b1;
               state_d = S_T6;
            end else begin
               reg_select = ra;
               Rin        = 1'b1;
               instr_done = 1'b1;
               state_d    = run ? S_T0 : S_IDLE;
            end
         end
         S_T6: begin
            Zhighout   = 1'b1;
            HIin       = 1'b1;
            instr_done = 1'b1;
            state_d    = run ? S_T0 : S_IDLE;
         end
         S_HALT: begin
            illegal = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected per-cycle output words are
// queued by the driver and compared by an independent negedge monitor.
module tb_control_sequencer;

   localparam int CNT_W = 2;
   localparam int W     = 16 + 4 + 4 + 1 + 1 + CNT_W;
   localparam logic [3:0] NONE = 4'd13;

   localparam logic [15:0] PCOUT    = 16'h8000;
   localparam logic [15:0] ZLOWOUT  = 16'h4000;
   localparam logic [15:0] ZHIGHOUT = 16'h2000;
   localparam logic [15:0] MDROUT   = 16'h1000;
   localparam logic [15:0] ROUT     = 16'h0800;
   localparam logic [15:0] MARIN    = 16'h0400;
   localparam logic [15:0] ZIN      = 16'h0200;
   localparam logic [15:0] PCIN     = 16'h0100;
   localparam logic [15:0] MDRIN    = 16'h0080;
   localparam logic [15:0] IRIN     = 16'h0040;
   localparam logic [15:0] YIN      = 16'h0020;
   localparam logic [15:0] RIN      = 16'h0010;
   localparam logic [15:0] HIIN     = 16'h0008;
   localparam logic [15:0] LOIN     = 16'h0004;
   localparam logic [15:0] INCPC    = 16'h0002;
   localparam logic [15:0] READ     = 16'h0001;

   logic clock = 1'b0;
   logic reset_n;
   logic run;
   logic [31:0] ir;
   logic mem_ready;
   logic PCout, Zlowout, Zhighout, MDRout, Rout;
   logic MARin, Zin, PCin, MDRin, IRin, Yin, Rin, HIin, LOin;
   logic IncPC, Read;
   logic [3:0] reg_select;
   logic [3:0] ALU_operation;
   logic instr_done, illegal;
   logic [CNT_W-1:0] retired;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_w;
   logic [CNT_W-1:0] exp_ret;
   int compared = 0;
   int mismatched = 0;

   control_sequencer #(.CNT_W(CNT_W)) dut (
      .clock(clock), .reset_n(reset_n), .run(run), .ir(ir), .mem_ready(mem_ready),
      .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .Rout(Rout),
      .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .Rin(Rin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
      .reg_select(reg_select), .ALU_operation(ALU_operation),
      .instr_done(instr_done), .illegal(illegal), .retired(retired)
   );

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   assign got_w = {PCout, Zlowout, Zhighout, MDRout, Rout, MARin, Zin, PCin, MDRin,
                   IRin, Yin, Rin, HIin, LOin, IncPC, Read,
                   reg_select, ALU_operation, instr_done, illegal, retired};

   function automatic logic [W-1:0] mkw(input logic [15:0] s, input logic [3:0] rs,
                                        input logic [3:0] alu, input logic done,
                                        input logic ill, input logic [CNT_W-1:0] ret);
      return {s, rs, alu, done, ill, ret};
   endfunction

   function automatic logic [31:0] enc(input int opc, input int ra, input int rb, input int rc);
      return {opc[4:0], ra[3:0], rb[3:0], rc[3:0], 15'b0};
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         logic [W-1:0] e;
         e = exp_q.pop_front();
         compared++;
         if (got_w !== e) begin
            mismatched++;
            $display("FAIL out_word t=%0t: got %h required %h", $time, got_w, e);
         end
      end
      if (reset_n === 1'b1) begin
         compared++;
         if ($countones({PCout, Zlowout, Zhighout, MDRout, Rout}) > 1) begin
            mismatched++;
            $display("FAIL bus_conflict t=%0t: got %b required at most one", $time,
                     {PCout, Zlowout, Zhighout, MDRout, Rout});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] e);
      compared++;
      if (got !== e) begin
         mismatched++;
         $display("FAIL %s t=%0t: got %h required %h", name, $time, got, e);
      end
   endtask

   task automatic step(input logic [W-1:0] e);
      @(posedge clock);
      #1;
      exp_q.push_back(e);
   endtask

   task automatic do_async_reset(input string name);
      @(negedge clock);
      #1;
      reset_n = 1'b0;
      run     = 1'b0;
      #1;
      exp_ret = '0;
      chk(name, got_w, mkw(16'h0, 4'd0, NONE, 1'b0, 1'b0, exp_ret));
      @(negedge clock);
      #1;
      reset_n = 1'b1;
      chk({name, "_idle"}, got_w, mkw(16'h0, 4'd0, NONE, 1'b0, 1'b0, exp_ret));
   endtask

   task automatic run_instr(input logic [31:0] instr, input int waits,
                            input logic run_after, input logic abort_t4);
      logic [4:0] opc;
      logic [3:0] ra, rb, rc;
      logic legal, unary, muldiv;
      opc    = instr[31:27];
      ra     = instr[26:23];
      rb     = instr[22:19];
      rc     = instr[18:15];
      legal  = (opc <= 5'd12);
      unary  = (opc == 5'd4) || (opc == 5'd5);
      muldiv = (opc == 5'd11) || (opc == 5'd12);
      mem_ready = (waits == 0);
      run = 1'b1;
      step(mkw(PCOUT | MARIN | INCPC | ZIN, 4'd0, NONE, 1'b0, 1'b0, exp_ret));
      ir = instr;
      step(mkw(ZLOWOUT | PCIN | READ | MDRIN, 4'd0, NONE, 1'b0, 1'b0, exp_ret));
      for (int i = 1; i <= waits; i++) begin
         step(mkw(READ | MDRIN, 4'd0, NONE, 1'b0, 1'b0, exp_ret));
         if (i == waits) mem_ready = 1'b1;
      end
      step(mkw(MDROUT | IRIN, 4'd0, NONE, 1'b0, 1'b0, exp_ret));
      if (!legal) begin
         step(mkw(16'h0, 4'd0, NONE, 1'b0, 1'b0, exp_ret));
         step(mkw(16'h0, 4'd0, NONE, 1'b0, 1'b1, exp_ret));
         return;
      end
      step(mkw(ROUT | YIN, rb, NONE, 1'b0, 1'b0, exp_ret));
      run = run_after;
      step(mkw((unary ? 16'h0 : ROUT) | ZIN, rc, opc[3:0], 1'b0, 1'b0, exp_ret));
      if (abort_t4) begin
         do_async_reset("reset_mid_t4");
         return;
      end
      if (muldiv) begin
         step(mkw(ZLOWOUT | LOIN, 4'd0, NONE, 1'b0, 1'b0, exp_ret));
         step(mkw(ZHIGHOUT | HIIN, 4'd0, NONE, 1'b1, 1'b0, exp_ret));
      end else begin
         step(mkw(ZLOWOUT | RIN, ra, NONE, 1'b1, 1'b0, exp_ret));
      end
      exp_ret = exp_ret + 1'b1;
      if (!run_after) step(mkw(16'h0, 4'd0, NONE, 1'b0, 1'b0, exp_ret));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_n   = 1'b0;
      run       = 1'b0;
      ir        = 32'h0;
      mem_ready = 1'b0;
      exp_ret   = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_state", got_w, mkw(16'h0, 4'd0, NONE, 1'b0, 1'b0, '0));
      @(negedge clock);
      #1;
      reset_n = 1'b1;

      // and R2,R5,R6: zero-wait fetch, then the same with three wait states
      run_instr(32'h112B0000, 0, 1'b0, 1'b0);
      run_instr(32'h112B0000, 3, 1'b1, 1'b0);
      // MUL back-to-back: LO in T5, HI in T6, no Rin
      run_instr(32'h59800000, 0, 1'b0, 1'b0);

      // opcode 13 traps; HALT ignores run until reset
      run_instr(32'h68000000, 0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         run = i[0];
         step(mkw(16'h0, 4'd0, NONE, 1'b0, 1'b1, exp_ret));
      end
      do_async_reset("reset_from_halt");

      // one retired instruction, then asynchronous reset in the middle of T4
      run_instr(enc(0, 7, 8, 9), 0, 1'b1, 1'b0);
      run_instr(32'h112B0000, 1, 1'b1, 1'b1);

      // four back-to-back instructions wrap the 2-bit counter; run drops in T3 of the last
      run_instr(enc(1, 1, 2, 3), 0, 1'b1, 1'b0);
      run_instr(enc(4, 4, 5, 6), 2, 1'b1, 1'b0);
      run_instr(enc(8, 15, 14, 13), 0, 1'b1, 1'b0);
      run_instr(enc(12, 9, 10, 11), 0, 1'b0, 1'b0);
      step(mkw(16'h0, 4'd0, NONE, 1'b0, 1'b0, exp_ret));

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
      @(negedge clock);
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d pending required 0", exp_q.size());
      end
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
